// File: rtl/trigger_frame_serializer.sv
// -----------------------------------------------------------------------------
// trigger_frame_serializer
//
// Purpose:
//   Takes one wide trigger frame (timestamps, threshold, baseline and 256 bits
//   of sample data) and sends it as seven 64-bit AXI-Stream words:
//     word 0 : header {8'hAA, 3'b000, THRESHOLD, SEQ, BASELINE, 12'h000}
//     word 1 : {16'h0000, TRIG_TIME}
//     word 2 : {16'h0000, END_TIME}
//     word 3..6 : DATA[63:0], DATA[127:64], DATA[191:128], DATA[255:192]
//   TLAST marks word 6. A new frame can be accepted on the same edge that
//   word 6 completes, so frames can stream with no idle gap.
//
// Ports:
//   M_AXIS_ACLK     in   sole clock, rising edge
//   M_AXIS_ARESETN  in   synchronous active-low reset
//   DIN             in   DIN_WIDTH trigger frame
//                        {TRIG_TIME, END_TIME, THRESHOLD, BASELINE, DATA}
//   iVALID          in   DIN valid
//   oREADY          out  DIN accepted when iVALID && oREADY
//   M_AXIS_TDATA    out  serialized 64-bit word
//   M_AXIS_TVALID   out  AXI-Stream valid
//   M_AXIS_TREADY   in   AXI-Stream ready
//   M_AXIS_TLAST    out  last word of a frame
//   oFRAME_CNT      out  number of frames fully sent (wraps at 16 bits)
// -----------------------------------------------------------------------------
module trigger_frame_serializer #(
    parameter int TIME_STAMP_WIDTH     = 48,
    parameter int ADC_RESOLUTION_WIDTH = 12,
    parameter int TDATA_WIDTH          = 256,
    parameter int DIN_WIDTH            = TDATA_WIDTH + TIME_STAMP_WIDTH*2
                                         + ADC_RESOLUTION_WIDTH*2 + 1,
    parameter int M_TDATA_WIDTH        = 64
) (
    input  logic                     M_AXIS_ACLK,
    input  logic                     M_AXIS_ARESETN,
    input  logic [DIN_WIDTH-1:0]     DIN,
    input  logic                     iVALID,
    output logic                     oREADY,
    output logic [M_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                     M_AXIS_TVALID,
    input  logic                     M_AXIS_TREADY,
    output logic                     M_AXIS_TLAST,
    output logic [15:0]              oFRAME_CNT
);

    // Field positions inside DIN (LSB of each field).
    localparam int BASE_LSB = TDATA_WIDTH;
    localparam int THR_LSB  = BASE_LSB + ADC_RESOLUTION_WIDTH;
    localparam int END_LSB  = THR_LSB + ADC_RESOLUTION_WIDTH + 1;
    localparam int TRIG_LSB = END_LSB + TIME_STAMP_WIDTH;

    localparam logic [2:0] LAST_IDX = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_idx;
    logic [DIN_WIDTH-1:0]   r_hold;
    logic [15:0]            r_seq;      // sequence number for the next frame
    logic [15:0]            r_hdr_seq;  // sequence number of the frame in flight
    logic [15:0]            r_frame_cnt;

    logic                   w_send;
    logic                   w_last;
    logic                   w_ready;
    logic                   w_accept;
    logic                   w_hs;

    // Select one 64-bit output word of a frame.
    function automatic logic [M_TDATA_WIDTH-1:0] f_word(
        input logic [2:0]           idx,
        input logic [DIN_WIDTH-1:0] frame,
        input logic [15:0]          seq
    );
        logic [M_TDATA_WIDTH-1:0] w;
        w = '0;
        case (idx)
            3'd0: w = {8'hAA, 3'b000,
                       frame[THR_LSB +: ADC_RESOLUTION_WIDTH+1],
                       seq,
                       frame[BASE_LSB +: ADC_RESOLUTION_WIDTH],
                       12'h000};
            3'd1: w = {16'h0000, frame[TRIG_LSB +: TIME_STAMP_WIDTH]};
            3'd2: w = {16'h0000, frame[END_LSB +: TIME_STAMP_WIDTH]};
            3'd3: w = frame[0   +: M_TDATA_WIDTH];
            3'd4: w = frame[64  +: M_TDATA_WIDTH];
            3'd5: w = frame[128 +: M_TDATA_WIDTH];
            3'd6: w = frame[192 +: M_TDATA_WIDTH];
            default: w = '0;
        endcase
        return w;
    endfunction

    assign w_send = (r_state == S_SEND);
    assign w_last = w_send && (r_idx == LAST_IDX);
    assign w_hs   = w_send && M_AXIS_TREADY;

    // Ready in IDLE, and also while the last word is completing so the next
    // frame is taken on the same edge. Gated by reset so nothing is offered
    // while the block is held in reset.
    assign w_ready  = M_AXIS_ARESETN &&
                      ((r_state == S_IDLE) || (w_last && M_AXIS_TREADY));
    assign w_accept = iVALID && w_ready;

    assign oREADY        = w_ready;
    assign M_AXIS_TVALID = w_send;
    assign M_AXIS_TLAST  = w_last;
    // Output word comes only from registered state; forced to zero outside SEND.
    assign M_AXIS_TDATA  = w_send ? f_word(r_idx, r_hold, r_hdr_seq) : '0;
    assign oFRAME_CNT    = r_frame_cnt;

    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            r_state     <= S_IDLE;
            r_idx       <= 3'd0;
            r_hold      <= '0;
            r_seq       <= 16'd0;
            r_hdr_seq   <= 16'd0;
            r_frame_cnt <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx <= 3'd0;
                end
                S_SEND: begin
                    if (w_hs) begin
                        if (r_idx == LAST_IDX) begin
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_idx       <= 3'd0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_idx   <= 3'd0;
                end
            endcase

            // A new frame overrides the return to IDLE above, giving a
            // gapless header after the last word.
            if (w_accept) begin
                r_hold    <= DIN;
                r_hdr_seq <= r_seq;
                r_seq     <= r_seq + 16'd1;
                r_idx     <= 3'd0;
                r_state   <= S_SEND;
            end
        end
    end

endmodule
